// File: rtl/edge_mode_sched_pkg.sv
// edge_mode_sched_pkg
// Shared definitions for the edge-pipeline mode sequencer:
//   - sequencer state encoding
//   - warm-up border widths per kernel (lines/columns discarded after a (re)start)
//   - default active-video geometry
//   - warmup_k(): maps a mode pair {grayscale, sobel_5} to its border width
package edge_mode_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [2:0] K_SOBEL5 = 3'd4;
    localparam logic [2:0] K_SOBEL3 = 3'd2;
    localparam logic [2:0] K_GRAY   = 3'd0;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;

    // Grayscale bypasses the kernels entirely, so it needs no border.
    function automatic logic [2:0] warmup_k(input logic gs, input logic s5);
        if (gs)      return K_GRAY;
        else if (s5) return K_SOBEL5;
        else         return K_SOBEL3;
    endfunction

endpackage

// File: rtl/edge_mode_sched_blank_delay.sv
// blank_delay
// 1-bit shift chain that delay-matches the blank qualifier to the datapath.
// Synchronous active-high reset fills every stage with 1, so nothing is
// marked valid until real qualifier values have propagated through.
// Ports:
//   clock  in  1  pixel clock
//   reset  in  1  synchronous, active-high
//   din    in  1  raw blank
//   dout   out 1  raw blank delayed DEPTH clocks
module blank_delay #(
    parameter int DEPTH = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clock) begin
        if (reset) begin
            taps <= '1;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/edge_mode_sched.sv
// edge_mode_sched
// Frame-synchronous sequencer for the grayscale / 3x3 / 5x5 Sobel edge
// pipeline. Switch requests and threshold changes are committed only at
// frame_start; a warm-up border is blanked after reset or a mode change, and
// the blank qualifier is delay-matched to the datapath output.
//
// Optional feature macro: EDGE_THRESH_ADJ_EN
//   defined   - thresh_up/thresh_down adjust a saturating shadow threshold,
//               copied to `threshold` at each frame_start
//   undefined - `threshold` is the constant THRESH_INIT, no registers built
//
// Ports:
//   clock        in  1   pixel clock, rising edge
//   reset        in  1   synchronous, active-high
//   hcount       in  11  horizontal pixel counter
//   vcount       in  10  vertical line counter
//   frame_start  in  1   pulse at hcount=0, vcount=0
//   grayscale_sw in  1   async switch, grayscale passthrough request
//   sobel5_sw    in  1   async switch, 1=5x5 kernel, 0=3x3
//   thresh_up    in  1   debounced pulse, raise threshold
//   thresh_down  in  1   debounced pulse, lower threshold
//   grayscale    out 1   committed grayscale mode
//   sobel_5      out 1   committed kernel select
//   threshold    out 8   committed threshold
//   blank        out 1   pixel leaving the datapath this cycle is invalid
//   pix_valid    out 1   ~blank
//   mode_busy    out 1   change pending or warm-up in progress
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for the first frame_start
// FILL  | kernel line buffers warming up, waiting for line_cnt >= K
// RUN   | output valid inside the border; commits mode changes at frame_start
module edge_mode_sched
    import edge_mode_sched_pkg::*;
#(
    parameter int         H_ACTIVE    = H_ACTIVE_DEF,
    parameter int         V_ACTIVE    = V_ACTIVE_DEF,
    parameter int         PIPE_LAT    = 6,
    parameter logic [7:0] THRESH_INIT = 8'd64,
    parameter logic [7:0] THRESH_STEP = 8'd8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        frame_start,
    input  logic        grayscale_sw,
    input  logic        sobel5_sw,
    input  logic        thresh_up,
    input  logic        thresh_down,
    output logic        grayscale,
    output logic        sobel_5,
    output logic [7:0]  threshold,
    output logic        blank,
    output logic        pix_valid,
    output logic        mode_busy
);

    state_t     state, state_nxt;
    logic       gs_meta, gs_sync, s5_meta, s5_sync;
    logic [1:0] req_mode;
    logic [2:0] line_cnt;
    logic [2:0] k;
    logic       commit;
    logic       raw_blank;

    // Synchronizers reset to the default committed mode so a quiet switch
    // bank does not look like a pending request straight out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            {gs_meta, gs_sync, s5_meta, s5_sync} <= 4'b0011;
        end else begin
            gs_meta <= grayscale_sw;
            gs_sync <= gs_meta;
            s5_meta <= sobel5_sw;
            s5_sync <= s5_meta;
        end
    end

    assign req_mode = {gs_sync, s5_sync};
    assign k        = warmup_k(grayscale, sobel_5);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (frame_start)     state_nxt = ST_FILL;
            ST_FILL: if (line_cnt >= k)   state_nxt = ST_RUN;
            ST_RUN:  if (commit)          state_nxt = ST_FILL;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        commit    = (state == ST_RUN) && frame_start && (req_mode != {grayscale, sobel_5});
        raw_blank = (state != ST_RUN)
                  || (hcount >= 11'(H_ACTIVE))
                  || (vcount >= 10'(V_ACTIVE))
                  || (vcount < {7'd0, k})
                  || (hcount < {8'd0, k});
        mode_busy = (req_mode != {grayscale, sobel_5}) || (state != ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grayscale <= 1'b0;
            sobel_5   <= 1'b1;
        end else if (commit) begin
            {grayscale, sobel_5} <= req_mode;
        end
    end

    // FILL is only ever entered on frame_start, so clearing here also
    // covers the "cleared on FILL entry" case.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_cnt <= 3'd0;
        end else if (frame_start) begin
            line_cnt <= 3'd0;
        end else if (hcount == 11'd0 && vcount < 10'(V_ACTIVE) && line_cnt != 3'd7) begin
            line_cnt <= line_cnt + 3'd1;
        end
    end

    blank_delay #(.DEPTH(PIPE_LAT)) u_blank_delay (
        .clock (clock),
        .reset (reset),
        .din   (raw_blank),
        .dout  (blank)
    );

    assign pix_valid = ~blank;

`ifdef EDGE_THRESH_ADJ_EN
    logic [7:0] shadow;
    logic [8:0] up_sum;

    assign up_sum = {1'b0, shadow} + {1'b0, THRESH_STEP};

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow    <= THRESH_INIT;
            threshold <= THRESH_INIT;
        end else begin
            if (frame_start) threshold <= shadow;
            if (thresh_up && !thresh_down) begin
                shadow <= up_sum[8] ? 8'd255 : up_sum[7:0];
            end else if (thresh_down && !thresh_up) begin
                shadow <= (shadow < THRESH_STEP) ? 8'd0 : shadow - THRESH_STEP;
            end
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = thresh_up ^ thresh_down ^ (|THRESH_STEP);
    assign threshold     = THRESH_INIT;
`endif

endmodule
